// File: rtl/led_light_scheduler_if.sv
// led_light_scheduler_if: control and status bundle between a lighting host and the scheduler.
// Latency: none; wires only.
// Backpressure: none; every signal is sampled or driven each clock.
// Ports:
//   btn_pulse   host->sched   single-cycle manual step pulse
//   mode_sw     host->sched   raw slide switch, asynchronous (1 = auto)
//   adc_value   host->sched   7-bit photo-sensor reading, lower = darker
//   adc_valid   host->sched   single-cycle strobe qualifying adc_value
//   duty        sched->host   7-bit PWM duty, registered
//   level       sched->host   selected target level 0..3
//   auto_active sched->host   sampled mode switch
//   fading      sched->host   duty has not yet reached the target duty
interface led_light_scheduler_if;
   logic       btn_pulse;
   logic       mode_sw;
   logic [6:0] adc_value;
   logic       adc_valid;
   logic [6:0] duty;
   logic [1:0] level;
   logic       auto_active;
   logic       fading;

   modport master (
      output btn_pulse, mode_sw, adc_value, adc_valid,
      input  duty, level, auto_active, fading
   );

   modport slave (
      input  btn_pulse, mode_sw, adc_value, adc_valid,
      output duty, level, auto_active, fading
   );
endinterface

// File: rtl/led_light_scheduler.sv
// led_light_scheduler: picks a manual or photo-sensor lighting level and fades the 7-bit PWM duty toward it.
// Latency: level/auto_active update one clk after their cause; duty moves 1 LSB per FADE_CYCLES clocks.
// Backpressure: none; btn_pulse and adc_valid are consumed on the cycle they are high.
// Ports:
//   clk      in  system clock
//   reset_p  in  asynchronous active-high reset
//   io_bus   slave side of led_light_scheduler_if (see interface file for the signal list)
module led_light_scheduler #(
   parameter int SW_SAMPLE_CYCLES = 65536,
   parameter int FADE_CYCLES      = 50000,
   parameter int HOLD_SAMPLES     = 4,
   parameter int HYST             = 3,
   parameter int TH3              = 15,
   parameter int TH2              = 40,
   parameter int TH1              = 60,
   parameter int DUTY1            = 42,
   parameter int DUTY2            = 84,
   parameter int DUTY3            = 127
) (
   input logic                  clk,
   input logic                  reset_p,
   led_light_scheduler_if.slave io_bus
);

   localparam int SW_W   = $clog2(SW_SAMPLE_CYCLES);
   localparam int FADE_W = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
   localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_SAMPLE_CYCLES - 1);
   localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_CYCLES - 1);
   localparam logic [3:0]        HOLD_N    = 4'(HOLD_SAMPLES);

   typedef enum logic [1:0] {
      MAN_OFF = 2'd0,
      MAN_L1  = 2'd1,
      MAN_L2  = 2'd2,
      MAN_L3  = 2'd3
   } man_state_t;

   // Level implied by the thresholds, each raised by offs.
   function automatic logic [1:0] f_adc_level(input logic [6:0] adc, input int offs);
      int v;
      v = int'(adc);
      if (v < TH3 + offs)      return 2'd3;
      else if (v < TH2 + offs) return 2'd2;
      else if (v < TH1 + offs) return 2'd1;
      else                     return 2'd0;
   endfunction

   function automatic logic [6:0] f_level_duty(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return 7'(DUTY1);
         2'd2:    return 7'(DUTY2);
         2'd3:    return 7'(DUTY3);
         default: return 7'd0;
      endcase
   endfunction

   man_state_t        r_man_state;
   logic              r_mode_meta;
   logic              r_mode_sync;
   logic              r_auto_active;
   logic [SW_W-1:0]   r_sw_cnt;
   logic [FADE_W-1:0] r_fade_cnt;
   logic [1:0]        r_auto_lvl;
   logic [1:0]        r_cand;
   logic [3:0]        r_hold_cnt;
   logic [1:0]        r_level;
   logic [6:0]        r_duty;
   logic              r_fading;

   logic              w_sw_tc;
   logic              w_fade_tc;
   logic              w_auto_nxt;
   logic              w_mode_chg;
   man_state_t        w_man_nxt;
   logic [1:0]        w_raw;
   logic [1:0]        w_cand;
   logic [3:0]        w_run;
   logic [1:0]        w_auto_lvl_nxt;
   logic [1:0]        w_cand_nxt;
   logic [3:0]        w_hold_cnt_nxt;
   logic [1:0]        w_level_nxt;
   logic [6:0]        w_target;
   logic [6:0]        w_duty_nxt;

   assign w_sw_tc    = (r_sw_cnt == SW_LAST);
   assign w_fade_tc  = (r_fade_cnt == FADE_LAST);
   assign w_auto_nxt = w_sw_tc ? r_mode_sync : r_auto_active;
   assign w_mode_chg = (w_auto_nxt != r_auto_active);

   // Brightening takes the raw level; dimming must clear the raised thresholds.
   assign w_raw  = f_adc_level(io_bus.adc_value, 0);
   assign w_cand = (w_raw > r_auto_lvl) ? w_raw :
                   (w_raw < r_auto_lvl) ? f_adc_level(io_bus.adc_value, HYST) :
                   r_auto_lvl;
   // Run length including this sample; a new candidate restarts the run.
   assign w_run  = ((w_cand == r_cand) && (r_hold_cnt != 4'd0)) ? (r_hold_cnt + 4'd1) : 4'd1;

   always_comb begin
      w_man_nxt = r_man_state;
      if (w_mode_chg) begin
         w_man_nxt = MAN_OFF;
      end else if (!r_auto_active && io_bus.btn_pulse) begin
         case (r_man_state)
            MAN_OFF: w_man_nxt = MAN_L1;
            MAN_L1:  w_man_nxt = MAN_L2;
            MAN_L2:  w_man_nxt = MAN_L3;
            default: w_man_nxt = MAN_OFF;
         endcase
      end
   end

   always_comb begin
      w_auto_lvl_nxt = r_auto_lvl;
      w_cand_nxt     = r_cand;
      w_hold_cnt_nxt = r_hold_cnt;
      if (w_mode_chg) begin
         w_auto_lvl_nxt = 2'd0;
         w_cand_nxt     = 2'd0;
         w_hold_cnt_nxt = 4'd0;
      end else if (r_auto_active && io_bus.adc_valid) begin
         if (w_cand == r_auto_lvl) begin
            w_hold_cnt_nxt = 4'd0;
         end else if (w_run == HOLD_N) begin
            w_auto_lvl_nxt = w_cand;
            w_hold_cnt_nxt = 4'd0;
         end else begin
            w_cand_nxt     = w_cand;
            w_hold_cnt_nxt = w_run;
         end
      end
   end

   assign w_level_nxt = w_auto_nxt ? w_auto_lvl_nxt : w_man_nxt;

   // Duty steps toward the target of the level currently shown.
   assign w_target = f_level_duty(r_level);

   always_comb begin
      w_duty_nxt = r_duty;
      if (w_fade_tc) begin
         if (r_duty < w_target)      w_duty_nxt = r_duty + 7'd1;
         else if (r_duty > w_target) w_duty_nxt = r_duty - 7'd1;
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_man_state   <= MAN_OFF;
         r_mode_meta   <= 1'b0;
         r_mode_sync   <= 1'b0;
         r_auto_active <= 1'b0;
         r_sw_cnt      <= '0;
         r_fade_cnt    <= '0;
         r_auto_lvl    <= 2'd0;
         r_cand        <= 2'd0;
         r_hold_cnt    <= 4'd0;
         r_level       <= 2'd0;
         r_duty        <= 7'd0;
         r_fading      <= 1'b0;
      end else begin
         r_mode_meta   <= io_bus.mode_sw;
         r_mode_sync   <= r_mode_meta;
         r_sw_cnt      <= w_sw_tc ? '0 : r_sw_cnt + 1'b1;
         r_fade_cnt    <= w_fade_tc ? '0 : r_fade_cnt + 1'b1;
         r_auto_active <= w_auto_nxt;
         r_man_state   <= w_man_nxt;
         r_auto_lvl    <= w_auto_lvl_nxt;
         r_cand        <= w_cand_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_level       <= w_level_nxt;
         r_duty        <= w_duty_nxt;
         // Compared against the next target so fading never lags a level change.
         r_fading      <= (w_duty_nxt != f_level_duty(w_level_nxt));
      end
   end

   assign io_bus.duty        = r_duty;
   assign io_bus.level       = r_level;
   assign io_bus.auto_active = r_auto_active;
   assign io_bus.fading      = r_fading;

endmodule

// File: tb/tb_led_light_scheduler.sv
// tb_led_light_scheduler: directed scenarios plus randomized stimulus against a reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_led_light_scheduler;
   localparam int SW   = 4;
   localparam int FADE = 2;
   localparam int HOLD = 4;
   localparam int HYSTP = 3;

   logic clk = 1'b0;
   logic reset_p;
   always #5 clk = ~clk;

   led_light_scheduler_if bus ();

   led_light_scheduler #(
      .SW_SAMPLE_CYCLES(SW),
      .FADE_CYCLES(FADE),
      .HOLD_SAMPLES(HOLD),
      .HYST(HYSTP)
   ) u_dut (
      .clk(clk),
      .reset_p(reset_p),
      .io_bus(bus.slave)
   );

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int duty_of(input int l);
      case (l)
         1: return 42;
         2: return 84;
         3: return 127;
         default: return 0;
      endcase
   endfunction

   function automatic int lvl_of(input int adc, input int off);
      if (adc < 15 + off) return 3;
      if (adc < 40 + off) return 2;
      if (adc < 60 + off) return 1;
      return 0;
   endfunction

   int m_s1, m_s2, m_auto, m_swc, m_fc, m_man, m_alvl, m_cnt, m_cand;
   int m_duty, m_level, m_fading;
   int mv_new_auto, mv_raw, mv_cand, mv_tgt, mv_adc;
   bit mv_chg;

   always @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         m_s1 = 0; m_s2 = 0; m_auto = 0; m_swc = 0; m_fc = 0;
         m_man = 0; m_alvl = 0; m_cnt = 0; m_cand = 0;
         m_duty = 0; m_level = 0; m_fading = 0;
      end else begin
         mv_new_auto = (m_swc == SW - 1) ? m_s2 : m_auto;
         m_swc = (m_swc + 1) % SW;
         mv_chg = (mv_new_auto != m_auto);
         m_s2 = m_s1;
         m_s1 = int'(bus.mode_sw);
         if (m_fc == FADE - 1) begin
            mv_tgt = duty_of(m_level);
            if (m_duty < mv_tgt) m_duty++;
            else if (m_duty > mv_tgt) m_duty--;
         end
         m_fc = (m_fc + 1) % FADE;
         if (mv_chg) begin
            m_man = 0; m_alvl = 0; m_cnt = 0;
         end else if (m_auto == 0 && bus.btn_pulse) begin
            m_man = (m_man + 1) % 4;
         end else if (m_auto == 1 && bus.adc_valid) begin
            mv_adc = int'(bus.adc_value);
            mv_raw = lvl_of(mv_adc, 0);
            if (mv_raw > m_alvl) mv_cand = mv_raw;
            else if (mv_raw < m_alvl) mv_cand = lvl_of(mv_adc, HYSTP);
            else mv_cand = m_alvl;
            if (mv_cand == m_alvl) m_cnt = 0;
            else begin
               if (m_cnt > 0 && mv_cand == m_cand) m_cnt++;
               else begin m_cnt = 1; m_cand = mv_cand; end
               if (m_cnt == HOLD) begin m_alvl = mv_cand; m_cnt = 0; end
            end
         end
         m_auto = mv_new_auto;
         m_level = (m_auto != 0) ? m_alvl : m_man;
         m_fading = (m_duty != duty_of(m_level)) ? 1 : 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("duty", int'(bus.duty), m_duty);
         chk("level", int'(bus.level), m_level);
         chk("auto_active", int'(bus.auto_active), m_auto);
         chk("fading", int'(bus.fading), m_fading);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic btn();
      @(negedge clk) bus.btn_pulse = 1'b1;
      @(negedge clk) bus.btn_pulse = 1'b0;
   endtask

   task automatic adc(input int v);
      @(negedge clk);
      bus.adc_valid = 1'b1;
      bus.adc_value = 7'(v);
      @(negedge clk) bus.adc_valid = 1'b0;
   endtask

   int scene;
   int scene_tab[8] = '{10, 14, 16, 18, 39, 42, 61, 70};

   initial begin
      reset_p = 1'b1;
      bus.btn_pulse = 1'b0;
      bus.mode_sw = 1'b0;
      bus.adc_value = 7'd0;
      bus.adc_valid = 1'b0;
      tick(3);
      chk("rst_duty", int'(bus.duty), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_auto", int'(bus.auto_active), 0);
      chk("rst_fading", int'(bus.fading), 0);
      reset_p = 1'b0;
      chk_en = 1'b1;
      tick(4);

      // 1: manual stepping and fades
      btn();       chk("t1_lvl1", int'(bus.level), 1);
      tick(100);   chk("t1_duty42", int'(bus.duty), 42); chk("t1_settled", int'(bus.fading), 0);
      btn();       chk("t1_lvl2", int'(bus.level), 2);
      tick(100);   chk("t1_duty84", int'(bus.duty), 84);
      btn();       chk("t1_lvl3", int'(bus.level), 3);
      tick(100);   chk("t1_duty127", int'(bus.duty), 127);
      btn();       chk("t1_lvl0", int'(bus.level), 0); chk("t1_fading", int'(bus.fading), 1);
      tick(300);   chk("t1_duty0", int'(bus.duty), 0);

      // 2: auto mode, hold confirmation
      bus.mode_sw = 1'b1;
      tick(12);    chk("t2_auto", int'(bus.auto_active), 1); chk("t2_lvl0", int'(bus.level), 0);
      repeat (3) adc(10);
      chk("t2_hold3", int'(bus.level), 0);
      adc(10);     chk("t2_hold4", int'(bus.level), 3);
      tick(300);   chk("t2_duty127", int'(bus.duty), 127);

      // 3: hysteresis on dimming
      repeat (4) adc(16);
      chk("t3_hyst_keep", int'(bus.level), 3);
      repeat (4) adc(18);
      chk("t3_hyst_dim", int'(bus.level), 2);
      tick(150);   chk("t3_duty84", int'(bus.duty), 84);

      // 4: alternating readings never confirm
      repeat (4) adc(70);
      chk("t4_lvl0", int'(bus.level), 0);
      tick(250);   chk("t4_duty0", int'(bus.duty), 0);
      for (int i = 0; i < 10; i++) begin adc(10); adc(70); end
      chk("t4_alt_lvl", int'(bus.level), 0);
      chk("t4_alt_duty", int'(bus.duty), 0);

      // 5: manual L2 then switch to auto
      bus.mode_sw = 1'b0;
      tick(12);    chk("t5_manual", int'(bus.auto_active), 0);
      btn(); btn(); chk("t5_lvl2", int'(bus.level), 2);
      tick(200);   chk("t5_duty84", int'(bus.duty), 84);
      bus.mode_sw = 1'b1;
      bus.adc_value = 7'd70;
      for (int i = 0; i < 20 && !bus.auto_active; i++) @(negedge clk);
      chk("t5_auto_edge", int'(bus.auto_active), 1);
      chk("t5_lvl_edge", int'(bus.level), 0);
      chk("t5_duty_edge", int'(bus.duty), 84);
      btn();       chk("t5_btn_ignored", int'(bus.level), 0);
      adc(70); adc(70);
      tick(200);   chk("t5_duty0", int'(bus.duty), 0);

      // 6: reset mid-fade
      bus.mode_sw = 1'b0;
      tick(12);
      btn(); btn(); btn();
      chk("t6_lvl3", int'(bus.level), 3);
      for (int i = 0; i < 300 && int'(bus.duty) != 60; i++) @(negedge clk);
      chk("t6_duty60", int'(bus.duty), 60);
      reset_p = 1'b1;
      #1;
      chk("t6_rst_duty", int'(bus.duty), 0);
      chk("t6_rst_level", int'(bus.level), 0);
      chk("t6_rst_fading", int'(bus.fading), 0);
      tick(2);
      reset_p = 1'b0;
      tick(20);
      chk("t6_post_level", int'(bus.level), 0);
      chk("t6_post_duty", int'(bus.duty), 0);
      chk("t6_post_fading", int'(bus.fading), 0);

      // randomized phase, checked cycle by cycle against the model
      scene = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset_p = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 59) == 0) bus.mode_sw = ~bus.mode_sw;
         if ($urandom_range(0, 29) == 0) scene = $urandom_range(0, 7);
         bus.btn_pulse = ($urandom_range(0, 7) == 0);
         bus.adc_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) bus.adc_value = 7'($urandom_range(0, 127));
         else bus.adc_value = 7'(scene_tab[scene]);
      end
      @(negedge clk);
      reset_p = 1'b0;
      bus.btn_pulse = 1'b0;
      bus.adc_valid = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
